ballot_collector: RTL
=====================

# ballot_collector

Sequential front end for the three-voter majority function: polls three voter stations in turn over a per-voter req/ack handshake, latches each vote, and produces the registered 2-of-3 majority with a one-cycle `done` pulse. Keeps saturating tallies of completed rounds and rounds that passed. Sits between the voter-station logic and the display/counter datapath; it is the initiator side of the ballot interface.

## Interface
- `CNT_W`, 8: width of the tally counters.
- `TIMEOUT`, 15: cycles a voter may take to acknowledge before it is marked abstaining (range 1..255).

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a ballot round; sampled only in IDLE.
- `vote_req` out 3: one-hot request, bit i polls voter i; all zero outside polling.
- `vote_ack` in 3: voter i acknowledges; only bit i is honoured, and only while `vote_req[i]` is high.
- `vote_val` in 3: voter i's vote, sampled together with `vote_ack[i]`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse, round complete.
- `result` out 1: majority of the last completed round; held until the next `done`.
- `abstain` out 3: bit i set when voter i timed out in the last round; updated with `done`.
- `round_cnt` out CNT_W: completed rounds, saturating.
- `yes_cnt` out CNT_W: rounds with `result`=1, saturating.

## Operation
- States: IDLE, ASK0, ASK1, ASK2, DONE.
- IDLE → ASK0 on `start`=1.
- ASKi: `vote_req` = 1<<i. On an edge with `vote_ack[i]`=1: latch `vote_val[i]` into vote bit i and clear abstain bit i, then go to ASK(i+1), or DONE after ASK2.
- Timeout: if a per-voter wait counter reaches `TIMEOUT` without ack, vote bit i = 0, abstain bit i = 1, then advance as for an ack. The wait counter clears on every state entry.
- DONE: `done`=1 for exactly one cycle, then IDLE. `result`, `abstain`, and the counters are registered on the ASK2→DONE edge.
- `result` = (v0&v1) | (v0&v2) | (v1&v2).
- `round_cnt` +1 per round. `yes_cnt` +1 when `result`=1. Both stick at all-ones with no wrap.
- `start` outside IDLE is ignored. Re-arming needs `start` in IDLE.
- Acks on non-requested bits are ignored and do not latch a vote.
- Reset values: state IDLE, `vote_req`=0, `busy`=0, `done`=0, `result`=0, `abstain`=0, `round_cnt`=0, `yes_cnt`=0, latched votes 0, wait counter 0.
- Reset asserted mid-round aborts the round: no `done`, counters cleared.

## Timing
- `start` sampled at edge k: `busy` and `vote_req`=001 from cycle k+1.
- Acks present immediately: `vote_req` 001, 010, 100 in cycles k+1..k+3; `done` high in cycle k+4; back in IDLE at k+5. Minimum round is 5 cycles edge-to-IDLE.
- `start` held high continuously: the next round begins the cycle after `done` (IDLE lasts 1 cycle).
- Timeout: voter i's request lasts exactly `TIMEOUT` cycles when no ack arrives.
- An ack arriving in the same cycle the timeout would fire wins: the vote is latched and abstain stays 0.

## Configuration
- `BALLOT_TIMEOUT_EN` defined: the timeout counter and `abstain` logic are present as above.
- Not defined: ASKi waits indefinitely for `vote_ack[i]`. `abstain` is tied to 0, the counter is not built, and `TIMEOUT` is unused.

## Structure
- Shared package `ballot_pkg`:
  - state enum `ballot_state_t` (IDLE, ASK0, ASK1, ASK2, DONE);
  - constant `NUM_VOTERS`=3;
  - majority function `maj3`.
- One sub-module, `sat_counter` (parameterised width, `inc` enable, saturating). Instantiated twice, for `round_cnt` and `yes_cnt`.

## Test plan
- Reset with `rst_n`=0 mid-ASK1 → all outputs 0, state IDLE, no `done`.
- `start` with votes 1,1,0 and acks on the first cycle of each request → `done` at k+4, `result`=1, `round_cnt`=1, `yes_cnt`=1.
- Votes 1,0,0 with voter 1 acking after 3 cycles → `vote_req`=010 held 3 cycles, `result`=0, `yes_cnt` unchanged.
- `BALLOT_TIMEOUT_EN` on, `TIMEOUT`=4, voter 2 silent, votes 1,1 → `vote_req`=100 for 4 cycles, `abstain`=100, `result`=1.
- `vote_ack`=110 during ASK0 → ignored, state holds ASK0; `start` pulsed while `busy` → no effect.
- `CNT_W`=2, 5 yes-rounds back-to-back → `round_cnt`=3 and `yes_cnt`=3 after the third round, staying 3.

Source files
------------

// File: rtl/ballot_pkg.sv
// ballot_pkg: shared definitions for the ballot collector.
//   ballot_state_t : FSM state encoding (IDLE, ASK0, ASK1, ASK2, DONE)
//   NUM_VOTERS     : number of polled voter stations
//   maj3           : 2-of-3 majority of a three-bit vote vector
package ballot_pkg;

  localparam int NUM_VOTERS = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ASK0 = 3'd1,
    ASK1 = 3'd2,
    ASK2 = 3'd3,
    DONE = 3'd4
  } ballot_state_t;

  function automatic logic maj3(input logic [NUM_VOTERS-1:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/ballot_collector_if.sv
// ballot_collector_if: per-voter request/acknowledge ballot bus.
//   vote_req : one-hot poll, driven by the collector (master)
//   vote_ack : voter i acknowledges its own request bit
//   vote_val : voter i's vote, valid together with vote_ack[i]
interface ballot_collector_if;
  import ballot_pkg::*;

  logic [NUM_VOTERS-1:0] vote_req;
  logic [NUM_VOTERS-1:0] vote_ack;
  logic [NUM_VOTERS-1:0] vote_val;

  modport master (
    output vote_req,
    input  vote_ack,
    input  vote_val
  );

  modport slave (
    input  vote_req,
    output vote_ack,
    output vote_val
  );

endinterface

// File: rtl/ballot_collector_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk, rst_n : clock, asynchronous active-low reset (clears to 0)
//   inc        : add one this cycle unless already saturated
//   cnt        : current count
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/ballot_collector.sv
// ballot_collector: polls three voter stations in turn, latches each vote
// and registers the 2-of-3 majority with a one-cycle done pulse. Keeps
// saturating tallies of completed rounds and of rounds that passed.
//
// Build option: define BALLOT_TIMEOUT_EN to give each voter TIMEOUT cycles
// to acknowledge before it is marked abstaining (vote forced to 0). Without
// it the collector waits indefinitely and abstain is always 0.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a round (only looked at in IDLE)
//   bus        : ballot bus, master side (vote_req / vote_ack / vote_val)
//   busy       : high outside IDLE
//   done       : one-cycle pulse when a round completes
//   result     : majority of the last completed round
//   abstain    : voters that timed out in the last completed round
//   round_cnt  : completed rounds (saturating)
//   yes_cnt    : completed rounds with result = 1 (saturating)
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | waiting for start
// ASK0  | polling voter 0 (vote_req = 001)
// ASK1  | polling voter 1 (vote_req = 010)
// ASK2  | polling voter 2 (vote_req = 100)
// DONE  | done pulse; result/abstain/tallies just updated
module ballot_collector
  import ballot_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  ballot_collector_if.master    bus,
  output logic                  busy,
  output logic                  done,
  output logic                  result,
  output logic [NUM_VOTERS-1:0] abstain,
  output logic [CNT_W-1:0]      round_cnt,
  output logic [CNT_W-1:0]      yes_cnt
);

  ballot_state_t         state_q, state_d;
  logic [NUM_VOTERS-1:0] votes_q, votes_d;
  logic [NUM_VOTERS-1:0] req;
  logic [1:0]            idx;
  logic                  asking;
  logic                  timed_out;
  logic                  hit_ack, hit_to, step, finish;
  logic                  result_q;

  // Which voter the current state is polling.
  always_comb begin
    idx    = 2'd0;
    asking = 1'b0;
    case (state_q)
      ASK0: begin idx = 2'd0; asking = 1'b1; end
      ASK1: begin idx = 2'd1; asking = 1'b1; end
      ASK2: begin idx = 2'd2; asking = 1'b1; end
      default: ;
    endcase
  end

  // Only the polled voter's ack bit is looked at; an ack in the same cycle
  // the timeout would fire takes precedence.
  assign hit_ack = asking & bus.vote_ack[idx];
  assign hit_to  = asking & ~bus.vote_ack[idx] & timed_out;
  assign step    = hit_ack | hit_to;
  assign finish  = step & (state_q == ASK2);

  always_comb begin
    votes_d = votes_q;
    if (step) begin
      votes_d[idx] = hit_ack & bus.vote_val[idx];
    end
  end

  always_comb begin
    state_d = state_q;
    req     = '0;
    if (asking) begin
      req[idx] = 1'b1;
    end
    case (state_q)
      IDLE:    if (start) state_d = ASK0;
      ASK0:    if (step)  state_d = ASK1;
      ASK1:    if (step)  state_d = ASK2;
      ASK2:    if (step)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      votes_q  <= '0;
      result_q <= 1'b0;
    end else begin
      state_q <= state_d;
      votes_q <= votes_d;
      if (finish) begin
        result_q <= maj3(votes_d);
      end
    end
  end

`ifdef BALLOT_TIMEOUT_EN
  logic [7:0]            wait_q;
  logic [NUM_VOTERS-1:0] abs_q, abs_d;
  logic [NUM_VOTERS-1:0] abstain_q;

  // Counts cycles spent in the current ASK state; any state change clears
  // it, so each voter gets a fresh window of exactly TIMEOUT cycles.
  assign timed_out = (wait_q == 8'(TIMEOUT - 1));

  always_comb begin
    abs_d = abs_q;
    if (step) begin
      abs_d[idx] = hit_to;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q    <= '0;
      abs_q     <= '0;
      abstain_q <= '0;
    end else begin
      abs_q <= abs_d;
      if (step || !asking) begin
        wait_q <= '0;
      end else begin
        wait_q <= wait_q + 8'd1;
      end
      if (finish) begin
        abstain_q <= abs_d;
      end
    end
  end

  assign abstain = abstain_q;
`else
  // TIMEOUT has no effect in this build.
  localparam int unused_timeout = TIMEOUT;

  assign timed_out = 1'b0;
  assign abstain   = '0;
`endif

  sat_counter #(.WIDTH(CNT_W)) u_round_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (finish),
    .cnt   (round_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_yes_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (finish & maj3(votes_d)),
    .cnt   (yes_cnt)
  );

  assign bus.vote_req = req;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign result       = result_q;

endmodule
